ldpc_input_framer: RTL and testbench
====================================

LDPC_INPUT_FRAMER -- requirements
Module: ldpc_input_framer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the width of the din/dout AXIS tdata.
REQ-002 The block SHALL have parameter CTRL_WIDTH, default 32, meaning the width of the ctrl AXIS tdata.
REQ-003 The block SHALL have parameter LEN_WIDTH, default 16, meaning the frame-length field at ctrl tdata[LEN_WIDTH-1:0], in beats.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port s_axis_ctrl, AxisIf.slave, CTRL_WIDTH: the frame descriptor input.
REQ-007 The block SHALL have port s_axis_din, AxisIf.slave, DATA_WIDTH: the raw LLR beats, with tlast from the source.
REQ-008 The block SHALL have port m_axis_ctrl, AxisIf.master, CTRL_WIDTH: the descriptor to the decoder loop.
REQ-009 The block SHALL have port m_axis_dout, AxisIf.master, DATA_WIDTH: the framed beats to the decoder loop.
REQ-010 The block SHALL have port frame_err, output, 1 bit: a one-cycle pulse on a length mismatch.
REQ-011 The block SHALL have port frame_cnt, output, 16 bits: the count of completed frames, wrapping at 65535->0.

Function
REQ-012 The FSM SHALL have states IDLE, CTRL, DATA and DRAIN.
REQ-013 In IDLE, s_axis_ctrl.tready SHALL be 1 and s_axis_din.tready SHALL be 0.
REQ-014 In IDLE, an accepted ctrl beat SHALL latch tdata, load remaining=len, and go to CTRL.
REQ-015 In IDLE, an accepted ctrl beat with len==0 SHALL pulse frame_err, emit nothing, and stay in IDLE.
REQ-016 In CTRL, the latched descriptor SHALL be presented on m_axis_ctrl with tvalid=1 and tlast=1, held stable until tready, and the state SHALL then go to DATA.
REQ-017 In DATA, the datapath SHALL be a single-register skid buffer with 1-cycle latency; a full-throughput stream of 1 beat/cycle SHALL be sustained while m_axis_dout.tready=1.
REQ-018 In DATA, each forwarded beat SHALL decrement remaining; m_axis_dout.tlast SHALL be 1 exactly on the beat where remaining==1.
REQ-019 If the input tlast coincides with remaining==1, the frame SHALL complete normally and the state SHALL go to IDLE.
REQ-020 If the input tlast arrives while remaining>1, that beat SHALL be forwarded with tlast=1, frame_err SHALL pulse, and the state SHALL go to IDLE (truncated frame).
REQ-021 If remaining reaches 0 without an input tlast, the state SHALL go to DRAIN and frame_err SHALL pulse.
REQ-022 In DRAIN, s_axis_din.tready SHALL be 1, beats SHALL be discarded, and the input tlast SHALL return the state to IDLE.
REQ-023 frame_cnt SHALL increment once per frame whose output tlast is accepted downstream, including truncated frames.
REQ-024 Output tvalid SHALL never depend combinationally on input tready; output tdata SHALL be held while tvalid && !tready.
REQ-025 s_axis_ctrl.tready SHALL be 0 in every state except IDLE, so a new ctrl is not accepted until the prior frame is fully done or drained.

Reset
REQ-026 rst=1 SHALL asynchronously force state=IDLE, every output tvalid=0, frame_err=0, frame_cnt=0, remaining=0 and the skid registers empty.
REQ-027 Reset asserted mid-frame SHALL abandon the frame with no tlast emitted; after reset deassertion the block SHALL wait for a new ctrl beat.
REQ-028 All tready outputs SHALL be 0 while rst=1.

Structure
REQ-029 The state enum and the LEN_WIDTH default SHALL live in the shared package ldpc_pkg.
REQ-030 The datapath register SHALL be the sub-module axis_skid_buffer, instantiated once on the din->dout path.
REQ-031 The implementation SHALL be 120-400 lines of RTL.

Verification
REQ-032 Nominal frame: ctrl len=4, then 4 din beats with tlast on beat 4 -> 1 ctrl beat out, 4 dout beats with tlast on beat 4, frame_err=0, frame_cnt=1.
REQ-033 Back-pressure: len=8 with m_axis_dout.tready toggling 1010... -> 8 beats out in order, no loss or duplication, data held stable while stalled.
REQ-034 Short input: len=6 with input tlast on beat 3 -> 3 beats out, tlast on beat 3, one frame_err pulse, state back to IDLE.
REQ-035 Long input: len=2 with 5 input beats, tlast on beat 5 -> 2 beats out, tlast on beat 2, frame_err pulse, 3 beats drained, next ctrl accepted afterwards.
REQ-036 len=0 ctrl -> no output on either master, frame_err pulse, frame_cnt unchanged.
REQ-037 Reset mid-frame: rst at beat 3 of a len=10 frame -> all tvalid=0 within the same cycle, frame_cnt=0, and a following len=1 frame completes normally.

Source files
------------

// File: rtl/ldpc_pkg.sv
// Shared definitions for the LDPC input framer: FSM state encoding and
// the default width of the descriptor frame-length field.
package ldpc_pkg;
    localparam int LEN_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        CTRL,
        DATA,
        DRAIN
    } frame_state_e;
endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream bundle used on every framer port.
interface AxisIf #(
    parameter int W = 32
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_skid_buffer.sv
// Single-register AXIS stage: one cycle of latency, full throughput, and the
// output beat stays frozen while the consumer stalls.
module axis_skid_buffer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid_i,
    input  logic         s_last_i,
    input  logic [W-1:0] s_data_i,
    output logic         s_ready_o,
    output logic         m_valid_o,
    output logic         m_last_o,
    output logic [W-1:0] m_data_o,
    input  logic         m_ready_i
);
    logic         valid_q, valid_d;
    logic [W:0]   data_q, data_d;

    always_comb begin
        s_ready_o = !valid_q || m_ready_i;
        valid_d   = valid_q;
        data_d    = data_q;
        if (s_ready_o) begin
            valid_d = s_valid_i;
            if (s_valid_i) data_d = {s_last_i, s_data_i};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign m_valid_o = valid_q;
    assign m_last_o  = data_q[W];
    assign m_data_o  = data_q[W-1:0];
endmodule

// File: rtl/ldpc_input_framer.sv
// Frames raw LLR beats against a length descriptor: forwards the descriptor,
// then exactly len beats (truncating or draining on a tlast mismatch).
module ldpc_input_framer
    import ldpc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 32,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    AxisIf.slave        s_axis_ctrl,
    AxisIf.slave        s_axis_din,
    AxisIf.master       m_axis_ctrl,
    AxisIf.master       m_axis_dout,
    output logic        frame_err,
    output logic [15:0] frame_cnt
);
    frame_state_e          state_q, state_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
    logic                  frame_err_q, frame_err_d;
    logic [15:0]           frame_cnt_q;

    logic [LEN_WIDTH-1:0]  ctrl_len;
    logic                  ctrl_fire, din_fire, drain_fire, frame_done;
    logic                  skid_in_valid, skid_in_ready, skid_in_last;
    logic                  unused_ctrl_tlast;

    assign unused_ctrl_tlast = s_axis_ctrl.tlast;
    assign ctrl_len          = s_axis_ctrl.tdata[LEN_WIDTH-1:0];

    // Readies are masked during reset since IDLE would otherwise accept ctrl.
    assign s_axis_ctrl.tready = (state_q == IDLE) && !rst;
    assign s_axis_din.tready  = !rst && (((state_q == DATA) && skid_in_ready) ||
                                         (state_q == DRAIN));

    assign ctrl_fire     = s_axis_ctrl.tvalid && s_axis_ctrl.tready;
    assign skid_in_valid = s_axis_din.tvalid && (state_q == DATA);
    assign din_fire      = skid_in_valid && skid_in_ready;
    assign drain_fire    = s_axis_din.tvalid && (state_q == DRAIN);
    assign skid_in_last  = s_axis_din.tlast || (remaining_q == LEN_WIDTH'(1));
    assign frame_done    = m_axis_dout.tvalid && m_axis_dout.tready && m_axis_dout.tlast;

    assign m_axis_ctrl.tdata  = ctrl_q;
    assign m_axis_ctrl.tvalid = (state_q == CTRL);
    assign m_axis_ctrl.tlast  = 1'b1;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        ctrl_d      = ctrl_q;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (ctrl_fire) begin
                    if (ctrl_len == '0) begin
                        frame_err_d = 1'b1;
                    end else begin
                        ctrl_d      = s_axis_ctrl.tdata;
                        remaining_d = ctrl_len;
                        state_d     = CTRL;
                    end
                end
            end
            CTRL: begin
                if (m_axis_ctrl.tready) state_d = DATA;
            end
            DATA: begin
                if (din_fire) begin
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (s_axis_din.tlast) begin
                        // Truncated when the source ends before the count does.
                        frame_err_d = (remaining_q != LEN_WIDTH'(1));
                        remaining_d = '0;
                        state_d     = IDLE;
                    end else if (remaining_q == LEN_WIDTH'(1)) begin
                        frame_err_d = 1'b1;
                        state_d     = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_fire && s_axis_din.tlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            ctrl_q      <= '0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            ctrl_q      <= ctrl_d;
            frame_err_q <= frame_err_d;
            if (frame_done) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_err = frame_err_q;
    assign frame_cnt = frame_cnt_q;

    axis_skid_buffer #(.W(DATA_WIDTH)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .s_valid_i (skid_in_valid),
        .s_last_i  (skid_in_last),
        .s_data_i  (s_axis_din.tdata),
        .s_ready_o (skid_in_ready),
        .m_valid_o (m_axis_dout.tvalid),
        .m_last_o  (m_axis_dout.tlast),
        .m_data_o  (m_axis_dout.tdata),
        .m_ready_i (m_axis_dout.tready)
    );
endmodule

// File: tb/tb_ldpc_input_framer.sv
// Bench for ldpc_input_framer: directed frame table, mid-frame reset, and
// random frames checked against a per-frame behavioural model.
module tb_ldpc_input_framer;
    logic        clk = 1'b0;
    logic        rst;
    logic        frame_err;
    logic [15:0] frame_cnt;

    AxisIf #(.W(32)) ctrl_s ();
    AxisIf #(.W(32)) din_s ();
    AxisIf #(.W(32)) ctrl_m ();
    AxisIf #(.W(32)) dout_m ();

    always #5 clk = ~clk;

    ldpc_input_framer #(.DATA_WIDTH(32), .CTRL_WIDTH(32), .LEN_WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_axis_ctrl (ctrl_s),
        .s_axis_din  (din_s),
        .m_axis_ctrl (ctrl_m),
        .m_axis_dout (dout_m),
        .frame_err   (frame_err),
        .frame_cnt   (frame_cnt)
    );

    typedef struct {
        int len;
        int nb;
        int mode;
        int exp_beats;
        int exp_err;
        int exp_ctrl;
    } vec_t;

    int          vectors = 0;
    int          miscompares = 0;
    int          rdy_mode = 0;
    int          exp_cnt = 0;
    int          err_seen = 0;
    int          hold_viol = 0;
    logic [32:0] doutq[$];
    logic [31:0] ctrlq[$];
    logic [31:0] sent[$];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Downstream ready patterns: 0 always ready, 1 toggling, 2 random.
    initial begin
        bit tog;
        tog = 1'b0;
        dout_m.tready = 1'b1;
        ctrl_m.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tog = ~tog;
            case (rdy_mode)
                0:       dout_m.tready = 1'b1;
                1:       dout_m.tready = tog;
                default: dout_m.tready = 1'($urandom_range(0, 1));
            endcase
            ctrl_m.tready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: records accepted beats, error pulses and stall-hold violations.
    initial begin
        logic        d_stall, c_stall;
        logic [32:0] d_hold;
        logic [31:0] c_hold;
        d_stall = 1'b0; c_stall = 1'b0; d_hold = '0; c_hold = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                d_stall = 1'b0;
                c_stall = 1'b0;
            end else begin
                if (d_stall && !(dout_m.tvalid && {dout_m.tlast, dout_m.tdata} == d_hold)) hold_viol++;
                if (c_stall && !(ctrl_m.tvalid && ctrl_m.tdata == c_hold)) hold_viol++;
                if (dout_m.tvalid && dout_m.tready) doutq.push_back({dout_m.tlast, dout_m.tdata});
                if (ctrl_m.tvalid && ctrl_m.tready) ctrlq.push_back(ctrl_m.tdata);
                if (frame_err) err_seen++;
                d_stall = dout_m.tvalid && !dout_m.tready;
                d_hold  = {dout_m.tlast, dout_m.tdata};
                c_stall = ctrl_m.tvalid && !ctrl_m.tready;
                c_hold  = ctrl_m.tdata;
            end
        end
    end

    task automatic send_ctrl(input logic [31:0] w);
        bit ok = 1'b0;
        ctrl_s.tdata  = w;
        ctrl_s.tvalid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = ctrl_s.tready;
            @(posedge clk);
            #1;
        end
        ctrl_s.tvalid = 1'b0;
        if (!ok) chk("ctrl_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last);
        bit ok = 1'b0;
        din_s.tdata  = d;
        din_s.tlast  = last;
        din_s.tvalid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = din_s.tready;
            @(posedge clk);
            #1;
        end
        din_s.tvalid = 1'b0;
        din_s.tlast  = 1'b0;
        if (!ok) chk("din_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_quiet();
        bit q = 1'b0;
        for (int i = 0; i < 300 && !q; i++) begin
            @(negedge clk);
            q = !dout_m.tvalid && !ctrl_m.tvalid;
        end
        if (!q) chk("drain_timeout", 64'd0, 64'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int len, input int nb, input int mode, input int exp_beats,
                             input int exp_err, input int exp_ctrl, input string tag);
        int          d0 = doutq.size();
        int          c0 = ctrlq.size();
        int          e0 = err_seen;
        int          h0 = hold_viol;
        logic [31:0] cw;
        logic [31:0] d;
        rdy_mode = mode;
        cw = $urandom;
        cw[15:0] = 16'(len);
        sent.delete();
        send_ctrl(cw);
        for (int b = 1; b <= nb; b++) begin
            d = $urandom;
            sent.push_back(d);
            send_beat(d, b == nb);
        end
        wait_quiet();
        exp_cnt += exp_ctrl;
        chk($sformatf("%s ctrl_beats", tag), 64'(ctrlq.size() - c0), 64'(exp_ctrl));
        if (exp_ctrl != 0 && ctrlq.size() > c0)
            chk($sformatf("%s ctrl_data", tag), 64'(ctrlq[c0]), 64'(cw));
        chk($sformatf("%s dout_beats", tag), 64'(doutq.size() - d0), 64'(exp_beats));
        for (int i = 0; i < exp_beats && d0 + i < doutq.size(); i++) begin
            chk($sformatf("%s beat%0d data", tag, i), 64'(doutq[d0+i][31:0]), 64'(sent[i]));
            chk($sformatf("%s beat%0d last", tag, i), 64'(doutq[d0+i][32]), 64'(i == exp_beats - 1));
        end
        chk($sformatf("%s err_pulses", tag), 64'(err_seen - e0), 64'(exp_err));
        chk($sformatf("%s frame_cnt", tag), 64'(frame_cnt), 64'(16'(exp_cnt)));
        chk($sformatf("%s hold", tag), 64'(hold_viol - h0), 64'd0);
    endtask

    initial begin
        vec_t tbl[7];
        int   d0, nlast, len, nb, mode, eb, ee, ec;

        tbl[0] = '{len: 4, nb: 4, mode: 0, exp_beats: 4, exp_err: 0, exp_ctrl: 1};
        tbl[1] = '{len: 8, nb: 8, mode: 1, exp_beats: 8, exp_err: 0, exp_ctrl: 1};
        tbl[2] = '{len: 6, nb: 3, mode: 0, exp_beats: 3, exp_err: 1, exp_ctrl: 1};
        tbl[3] = '{len: 2, nb: 5, mode: 0, exp_beats: 2, exp_err: 1, exp_ctrl: 1};
        tbl[4] = '{len: 0, nb: 0, mode: 0, exp_beats: 0, exp_err: 1, exp_ctrl: 0};
        tbl[5] = '{len: 1, nb: 1, mode: 2, exp_beats: 1, exp_err: 0, exp_ctrl: 1};
        tbl[6] = '{len: 3, nb: 3, mode: 2, exp_beats: 3, exp_err: 0, exp_ctrl: 1};

        rst = 1'b1;
        ctrl_s.tvalid = 1'b0; ctrl_s.tdata = '0; ctrl_s.tlast = 1'b1;
        din_s.tvalid  = 1'b0; din_s.tdata  = '0; din_s.tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst dout_tvalid", 64'(dout_m.tvalid), 64'd0);
        chk("rst ctrl_tvalid", 64'(ctrl_m.tvalid), 64'd0);
        chk("rst ctrl_tready", 64'(ctrl_s.tready), 64'd0);
        chk("rst din_tready", 64'(din_s.tready), 64'd0);
        chk("rst frame_err", 64'(frame_err), 64'd0);
        chk("rst frame_cnt", 64'(frame_cnt), 64'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle ctrl_tready", 64'(ctrl_s.tready), 64'd1);
        chk("idle din_tready", 64'(din_s.tready), 64'd0);

        for (int v = 0; v < 7; v++)
            run_frame(tbl[v].len, tbl[v].nb, tbl[v].mode, tbl[v].exp_beats,
                      tbl[v].exp_err, tbl[v].exp_ctrl, $sformatf("tbl%0d", v));

        // Reset on the third beat of a len=10 frame.
        rdy_mode = 0;
        d0 = doutq.size();
        send_ctrl(32'h00AB_000A);
        send_beat(32'h1111_0001, 1'b0);
        send_beat(32'h1111_0002, 1'b0);
        din_s.tdata  = 32'h1111_0003;
        din_s.tvalid = 1'b1;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst dout_tvalid", 64'(dout_m.tvalid), 64'd0);
        chk("midrst ctrl_tvalid", 64'(ctrl_m.tvalid), 64'd0);
        chk("midrst frame_cnt", 64'(frame_cnt), 64'd0);
        chk("midrst din_tready", 64'(din_s.tready), 64'd0);
        chk("midrst ctrl_tready", 64'(ctrl_s.tready), 64'd0);
        din_s.tvalid = 1'b0;
        nlast = 0;
        for (int i = d0; i < doutq.size(); i++) if (doutq[i][32]) nlast++;
        chk("midrst no_tlast", 64'(nlast), 64'd0);
        exp_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        run_frame(1, 1, 0, 1, 0, 1, "post_rst");

        // Random frames: model says a frame forwards min(len, source beats),
        // errors unless the source length matches, and counts iff len>0.
        for (int f = 0; f < 40; f++) begin
            len  = $urandom_range(0, 12);
            mode = $urandom_range(0, 2);
            if (len == 0) nb = 0;
            else case ($urandom_range(0, 3))
                0, 1:    nb = len;
                2:       nb = $urandom_range(1, len);
                default: nb = len + $urandom_range(1, 4);
            endcase
            ec = (len > 0) ? 1 : 0;
            eb = (len == 0) ? 0 : ((nb < len) ? nb : len);
            ee = (len == 0 || nb != len) ? 1 : 0;
            run_frame(len, nb, mode, eb, ee, ec, $sformatf("rnd%0d", f));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
